// File: rtl/jtag_scan_master.sv
// Host-side JTAG sequencer: walks a target TAP through one IR/DR scan per request
// (or a forced Test-Logic-Reset), driving TMS/TDI on negedge TCK and capturing TDO on posedge.
module jtag_scan_master #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
) (
    input  logic               TCK,
    input  logic               TRST,
    input  logic               REQ,
    input  logic               RESET_REQ,
    input  logic               IR_NDR,
    input  logic [LEN_W-1:0]   LEN,
    input  logic [MAX_LEN-1:0] DATA_IN,
    output logic               BUSY,
    output logic               DONE,
    output logic               ERR,
    output logic [MAX_LEN-1:0] DATA_OUT,
    output logic               TMS_OUT,
    output logic               TDI_OUT,
    input  logic               TDO_IN
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] TLR_LAST = LEN_W'(5);
    localparam logic [LEN_W-1:0] MAX_L    = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {TLR_SEQ, IDLE, BAD_LEN, PRE, SHIFT, POST} state_t;

    state_t             state, state_n;
    logic [LEN_W-1:0]   cnt, cnt_n, cnt_inc, len_q, pre_last;
    logic               ir_q;
    logic [MAX_LEN-1:0] data_q, cap, mask, dout_n;
    logic               tms_n, tdi_n, busy_n, done_n, err_n, load;

    assign cnt_inc  = cnt + 1'b1;
    // Preamble is 1,0,0 for DR; IR inserts a second 1 to pass through Select-IR.
    assign pre_last = ir_q ? LEN_W'(3) : LEN_W'(2);

    always_comb begin
        for (int k = 0; k < MAX_LEN; k++) mask[k] = (k < int'(len_q));
    end

    // Each state describes the bit currently on the pins; the next-state logic
    // therefore computes the value to present on the following TCK cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tms_n   = 1'b0;
        tdi_n   = 1'b0;
        busy_n  = 1'b1;
        done_n  = 1'b0;
        err_n   = 1'b0;
        load    = 1'b0;
        dout_n  = DATA_OUT;
        case (state)
            TLR_SEQ: begin
                if (cnt == TLR_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                    tms_n = (cnt_inc < TLR_LAST);
                end
            end
            IDLE: begin
                busy_n = 1'b0;
                cnt_n  = '0;
                if (RESET_REQ) begin
                    state_n = TLR_SEQ;
                    tms_n   = 1'b1;
                    busy_n  = 1'b1;
                end else if (REQ) begin
                    load   = 1'b1;
                    busy_n = 1'b1;
                    if (LEN == '0 || LEN > MAX_L) begin
                        state_n = BAD_LEN;
                    end else begin
                        state_n = PRE;
                        tms_n   = 1'b1;
                    end
                end
            end
            BAD_LEN: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                done_n  = 1'b1;
                err_n   = 1'b1;
            end
            PRE: begin
                if (cnt == pre_last) begin
                    state_n = SHIFT;
                    cnt_n   = '0;
                    tms_n   = (len_q == LEN_W'(1));
                    tdi_n   = data_q[0];
                end else begin
                    cnt_n = cnt_inc;
                    tms_n = ir_q && (cnt == '0);
                end
            end
            SHIFT: begin
                if (cnt == len_q - 1'b1) begin
                    state_n = POST;
                    cnt_n   = '0;
                    tms_n   = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                    tdi_n = data_q[cnt_inc[IDX_W-1:0]];
                    tms_n = (cnt_inc == len_q - 1'b1);
                end
            end
            POST: begin
                if (cnt == '0) begin
                    cnt_n = cnt_inc;
                end else begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    dout_n  = cap & mask;
                end
            end
            default: begin
                state_n = TLR_SEQ;
                cnt_n   = '0;
                tms_n   = 1'b1;
            end
        endcase
    end

    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST) begin
            state    <= TLR_SEQ;
            cnt      <= '0;
            TMS_OUT  <= 1'b1;
            TDI_OUT  <= 1'b0;
            BUSY     <= 1'b1;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            DATA_OUT <= '0;
            ir_q     <= 1'b0;
            len_q    <= '0;
            data_q   <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            TMS_OUT  <= tms_n;
            TDI_OUT  <= tdi_n;
            BUSY     <= busy_n;
            DONE     <= done_n;
            ERR      <= err_n;
            DATA_OUT <= dout_n;
            if (load) begin
                ir_q   <= IR_NDR;
                len_q  <= LEN;
                data_q <= DATA_IN;
            end
        end
    end

    // The target shifts on the same posedge, so TDO here is the bit it presented for this cycle.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) cap <= '0;
        else if (state == SHIFT) cap[cnt[IDX_W-1:0]] <= TDO_IN;
    end

endmodule

// File: tb/tb_jtag_scan_master.sv
// Randomized bench for jtag_scan_master: expected pin sequences come from the scan rules,
// and a behavioural 16-state TAP target closes the loop on TDO and the final TAP state.
module tb_jtag_scan_master;
    localparam int MAX_LEN = 32;
    localparam int LEN_W   = 6;

    localparam int TLR_S = 0,  RTI = 1,  SEL_DR = 2,  CAP_DR = 3,  SH_DR = 4,  EX1_DR = 5,
                   PAU_DR = 6, EX2_DR = 7, UPD_DR = 8, SEL_IR = 9, CAP_IR = 10, SH_IR = 11,
                   EX1_IR = 12, PAU_IR = 13, EX2_IR = 14, UPD_IR = 15;

    logic TCK = 1'b0;
    logic TRST, REQ, RESET_REQ, IR_NDR, TDO_IN;
    logic [LEN_W-1:0]   LEN;
    logic [MAX_LEN-1:0] DATA_IN, DATA_OUT;
    logic BUSY, DONE, ERR, TMS_OUT, TDI_OUT;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_dout;

    int tap_st = TLR_S;
    logic dr_bit = 1'b0;
    logic [31:0] ir_sr = '0;
    logic [31:0] ir_reg = '0;
    int ir_len = 4;

    jtag_scan_master #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .TCK(TCK), .TRST(TRST), .REQ(REQ), .RESET_REQ(RESET_REQ), .IR_NDR(IR_NDR),
        .LEN(LEN), .DATA_IN(DATA_IN), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .DATA_OUT(DATA_OUT), .TMS_OUT(TMS_OUT), .TDI_OUT(TDI_OUT), .TDO_IN(TDO_IN)
    );

    always #5 TCK = ~TCK;

    function automatic int tap_next(input int s, input logic t);
        case (s)
            TLR_S:  return t ? TLR_S  : RTI;
            RTI:    return t ? SEL_DR : RTI;
            SEL_DR: return t ? SEL_IR : CAP_DR;
            CAP_DR: return t ? EX1_DR : SH_DR;
            SH_DR:  return t ? EX1_DR : SH_DR;
            EX1_DR: return t ? UPD_DR : PAU_DR;
            PAU_DR: return t ? EX2_DR : PAU_DR;
            EX2_DR: return t ? UPD_DR : SH_DR;
            UPD_DR: return t ? SEL_DR : RTI;
            SEL_IR: return t ? TLR_S  : CAP_IR;
            CAP_IR: return t ? EX1_IR : SH_IR;
            SH_IR:  return t ? EX1_IR : SH_IR;
            EX1_IR: return t ? UPD_IR : PAU_IR;
            PAU_IR: return t ? EX2_IR : PAU_IR;
            EX2_IR: return t ? UPD_IR : SH_IR;
            default: return t ? SEL_DR : RTI;
        endcase
    endfunction

    // Target TAP: 1-bit DR that captures 1, IR of ir_len bits that captures ...01.
    always @(posedge TCK) begin
        case (tap_st)
            CAP_DR: dr_bit = 1'b1;
            SH_DR:  dr_bit = TDI_OUT;
            CAP_IR: ir_sr = 32'd1;
            SH_IR: begin
                ir_sr = ir_sr >> 1;
                ir_sr[ir_len-1] = TDI_OUT;
            end
            UPD_IR: ir_reg = ir_sr;
            default: ;
        endcase
        tap_st = tap_next(tap_st, TMS_OUT);
    end

    always @(negedge TCK)
        TDO_IN = (tap_st == SH_DR) ? dr_bit : (tap_st == SH_IR) ? ir_sr[0] : 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] len_mask(input int len);
        return (len >= 32) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1);
    endfunction

    // Called right after the edge that entered the TLR sequence; k counts cycles from that entry.
    task automatic expect_tlr(input int first);
        for (int k = first; k <= 6; k++) begin
            @(posedge TCK);
            if (k < 6) begin
                chk("tlr_tms", TMS_OUT, (k < 5) ? 1 : 0);
                chk("tlr_busy", BUSY, 1);
                chk("tlr_done", DONE, 0);
            end else begin
                chk("tlr_done_end", DONE, 1);
                chk("tlr_busy_end", BUSY, 0);
                chk("tlr_err", ERR, 0);
                chk("tlr_dout", DATA_OUT, exp_dout);
            end
            if (k == 0) begin
                #1 RESET_REQ = 1'b0;
            end
        end
        #1 chk("tlr_tap_rti", tap_st, RTI);
    endtask

    task automatic run_scan(input logic ir, input int len, input logic [31:0] data,
                            input bit keep, input int gap);
        bit tq[$];
        bit dq[$];
        logic [31:0] msk, edout;
        tq.push_back(1'b1); dq.push_back(1'b0);
        if (ir) begin tq.push_back(1'b1); dq.push_back(1'b0); end
        tq.push_back(1'b0); dq.push_back(1'b0);
        tq.push_back(1'b0); dq.push_back(1'b0);
        for (int i = 0; i < len; i++) begin
            tq.push_back(i == len - 1);
            dq.push_back(data[i]);
        end
        tq.push_back(1'b1); dq.push_back(1'b0);
        tq.push_back(1'b0); dq.push_back(1'b0);
        msk   = len_mask(len);
        edout = ir ? 32'd1 : (((data << 1) | 32'd1) & msk);
        ir_len = len;
        #1;
        IR_NDR = ir; LEN = LEN_W'(len); DATA_IN = data; REQ = 1'b1;
        @(negedge TCK);
        for (int k = 0; k < tq.size(); k++) begin
            @(posedge TCK);
            chk("scan_tms", TMS_OUT, tq[k]);
            chk("scan_tdi", TDI_OUT, dq[k]);
            chk("scan_busy", BUSY, 1);
            chk("scan_done", DONE, 0);
            if (k == 0 && !keep) begin
                #1 REQ = 1'b0;
            end
        end
        @(posedge TCK);
        chk("scan_done_end", DONE, 1);
        chk("scan_busy_end", BUSY, 0);
        chk("scan_err", ERR, 0);
        chk("scan_dout", DATA_OUT, edout);
        exp_dout = edout;
        #1 chk("scan_tap_rti", tap_st, RTI);
        if (ir) chk("scan_ir_reg", ir_reg & msk, data & msk);
        if (!keep) begin
            repeat (gap) begin
                @(posedge TCK);
                chk("idle_busy", BUSY, 0);
                chk("idle_tms", TMS_OUT, 0);
                chk("idle_done", DONE, 0);
            end
        end
    endtask

    task automatic run_bad(input int len);
        #1;
        IR_NDR = $urandom_range(0, 1); LEN = LEN_W'(len); DATA_IN = $urandom; REQ = 1'b1;
        @(negedge TCK);
        @(posedge TCK);
        chk("bad_tms", TMS_OUT, 0);
        chk("bad_busy", BUSY, 1);
        chk("bad_done", DONE, 0);
        #1 REQ = 1'b0;
        @(posedge TCK);
        chk("bad_done_end", DONE, 1);
        chk("bad_err", ERR, 1);
        chk("bad_busy_end", BUSY, 0);
        chk("bad_tms_end", TMS_OUT, 0);
        chk("bad_dout", DATA_OUT, exp_dout);
    endtask

    initial begin
        logic [31:0] d;
        TRST = 1'b1; REQ = 1'b0; RESET_REQ = 1'b0; IR_NDR = 1'b0; LEN = '0; DATA_IN = '0;
        exp_dout = '0;
        repeat (3) @(posedge TCK);
        chk("rst_tms", TMS_OUT, 1);
        chk("rst_tdi", TDI_OUT, 0);
        chk("rst_busy", BUSY, 1);
        chk("rst_done", DONE, 0);
        chk("rst_err", ERR, 0);
        chk("rst_dout", DATA_OUT, 0);
        #1 TRST = 1'b0;
        expect_tlr(1);

        run_scan(1'b0, 8, 32'hA5, 1'b0, 1);
        run_scan(1'b1, 4, 32'h3, 1'b0, 1);
        chk("ir_is_3", ir_reg[3:0], 4'h3);
        run_bad(0);
        run_bad(33);

        // RESET_REQ wins over REQ; REQ left high then launches the scan right after DONE.
        d = $urandom;
        #1 RESET_REQ = 1'b1; REQ = 1'b1; IR_NDR = 1'b0; LEN = LEN_W'(12); DATA_IN = d;
        @(negedge TCK);
        expect_tlr(0);
        run_scan(1'b0, 12, d, 1'b0, 1);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 9) == 0)
                run_bad(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(33, 63)));
            else
                run_scan(1'($urandom_range(0, 1)), int'($urandom_range(1, MAX_LEN)), $urandom,
                         (n != 29) && ($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)));
        end
        run_scan(1'b0, MAX_LEN, $urandom, 1'b0, 1);

        // Abort a 16-bit DR scan during shift cycle 3.
        d = $urandom;
        #1 IR_NDR = 1'b0; LEN = LEN_W'(16); DATA_IN = d; REQ = 1'b1;
        @(negedge TCK);
        for (int k = 0; k <= 6; k++) begin
            @(posedge TCK);
            chk("abort_pre_tms", TMS_OUT, (k == 0) ? 1 : 0);
            chk("abort_pre_tdi", TDI_OUT, (k < 3) ? 1'b0 : d[k-3]);
            if (k == 0) begin
                #1 REQ = 1'b0;
            end
        end
        #1 TRST = 1'b1;
        #1;
        chk("abort_tms", TMS_OUT, 1);
        chk("abort_busy", BUSY, 1);
        chk("abort_done", DONE, 0);
        chk("abort_dout", DATA_OUT, 0);
        exp_dout = '0;
        @(posedge TCK);
        @(posedge TCK);
        #1 TRST = 1'b0;
        expect_tlr(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jtag_scan_master.md
Name: jtag_scan_master

Overview:
- Host-side JTAG sequencer that drives a target TAP through complete IR or DR scans, generating TMS/TDI and capturing TDO.
- Sits between on-chip test/debug logic (requester) and the JTAG pins of a TAP controller; it shadows the target TAP state internally.
- One scan per request over a REQ/BUSY/DONE handshake; it can also force the target to Test-Logic-Reset.

Parameters:
- MAX_LEN, 32, maximum scan length in bits (IR or DR)
- LEN_W, 6, width of LEN; must hold MAX_LEN

Ports:
- TCK  input  1  scan clock, shared with target TAP
- TRST  input  1  asynchronous active-high reset
- REQ  input  1  scan request, level; sampled only when idle
- RESET_REQ  input  1  request to drive target into Test-Logic-Reset
- IR_NDR  input  1  1 = IR scan, 0 = DR scan
- LEN  input  LEN_W  number of bits to shift, valid 1..MAX_LEN
- DATA_IN  input  MAX_LEN  bits shifted to TDI, LSB first
- BUSY  output  1  high while a sequence is in progress
- DONE  output  1  one-cycle pulse when a sequence completes
- ERR  output  1  one-cycle pulse with DONE when LEN is illegal
- DATA_OUT  output  MAX_LEN  captured TDO bits, LSB = first shifted; unused MSBs 0
- TMS_OUT  output  1  to target TMS
- TDI_OUT  output  1  to target TDI
- TDO_IN  input  1  from target TDO

Behaviour:
- Clocking: the FSM, TMS_OUT, TDI_OUT, BUSY, DONE and ERR update on negedge TCK, so the target sees stable values at posedge. TDO_IN is sampled on posedge TCK into the capture shift register. DATA_OUT updates on the negedge at which DONE rises.
- Reset (TRST=1, async): FSM enters TLR_SEQ with counter 0. Reset values: TMS_OUT=1, TDI_OUT=0, BUSY=1, DONE=0, ERR=0, DATA_OUT=0.
- TLR_SEQ: drives TMS_OUT=1 for 5 TCK cycles, then 1 cycle of TMS_OUT=0 to reach Run-Test/Idle. It then enters IDLE, pulses DONE and drops BUSY.
- IDLE: TMS_OUT=0, TDI_OUT=0, BUSY=0. On a negedge with RESET_REQ=1, it enters TLR_SEQ; RESET_REQ has priority over REQ. Otherwise, if REQ=1, IR_NDR, LEN and DATA_IN are latched and BUSY=1 from that edge.
- Illegal LEN (0 or >MAX_LEN): no TMS activity; next cycle DONE=1, ERR=1, BUSY=0. DATA_OUT is unchanged.
- DR scan TMS sequence, one bit per TCK cycle: 1 (Select-DR), 0 (Capture-DR), 0 (Shift-DR entry), then LEN shift cycles.
  - During shift cycle i, TDI_OUT=DATA_IN[i]. TMS_OUT=0 for i<LEN-1 and 1 on i=LEN-1 (to Exit1).
  - Then 1 (Update-DR), then 0 (Run-Test/Idle).
- IR scan: same as DR scan with an extra leading 1 (Select-DR then Select-IR).
- Total cycles from the accept edge to DONE: DR = LEN+5, IR = LEN+6. DONE is asserted on the edge that returns to IDLE; BUSY falls on that same edge.
- TDO capture: on the posedge that ends shift cycle i, TDO_IN is sampled into bit i. DATA_OUT = captured bits with bits >= LEN cleared.
- TDI_OUT is 0 in all non-shift cycles.
- REQ held high after DONE starts a new scan on the next negedge (back-to-back operation). No extra idle cycle is required beyond the 1 IDLE cycle.
- REQ and RESET_REQ are ignored while BUSY=1.
- TRST mid-scan aborts immediately: outputs take their reset values and the TLR sequence restarts. DATA_OUT is cleared and no DONE is issued for the aborted scan.

Test Plan:
- Reset: pulse TRST, observe TMS_OUT=1 for 5 cycles then 0. DONE pulses after 6 cycles, BUSY=0, DATA_OUT=0.
- DR scan, LEN=8, DATA_IN=0xA5, with a loopback model (TDO follows TDI through a 1-bit target shift register preloaded with 1).
  - TMS pattern 1,0,0,0000000 1,1,0.
  - TDI bits 1,0,1,0,0,1,0,1.
  - DONE 13 cycles after accept; DATA_OUT matches the model capture.
- IR scan, LEN=4, DATA_IN=0x3, against a behavioural TAP model: TMS pattern 1,1,0,0,0001,1,0. Model IR=0x3 after Update-IR; DONE 10 cycles after accept.
- LEN=0 and LEN=33 with MAX_LEN=32: TMS stays 0; DONE and ERR pulse together 1 cycle after accept; DATA_OUT unchanged.
- REQ and RESET_REQ asserted together in IDLE: the TLR sequence runs and the scan is not performed. REQ still high afterwards: the scan starts on the negedge after DONE.
- TRST asserted during shift cycle 3 of a 16-bit DR scan: TMS_OUT=1 immediately, BUSY=1, no DONE for the scan. The TLR sequence completes and the model TAP ends in Run-Test/Idle.
